cordic_req_arbiter: RTL and testbench

- Shares one pipelined CORDIC datapath between two requesters, A and B. Either requester can issue rotation or vectoring operations.
- Performs round-robin arbitration and issues at most one operation per cycle into the fixed-latency datapath.
- Tags every in-flight operation, steers each returning result into the owning requester's response FIFO, and uses credits so that a FIFO can never overflow.
- Sits between the top-level requesters and the rotation/vectoring pipeline.

---
 rtl/cordic_req_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_cordic_req_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_req_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_req_arbiter
//
// Shares one fixed-latency, pipelined CORDIC datapath between two requesters
// (A and B). Requests are arbitrated round-robin and at most one operation per
// cycle is issued. Each operation is tagged with its owner and mode. Returning
// results are steered into that owner's response FIFO. Per-requester credits
// bound the number of outstanding operations, so a FIFO can never overflow
// even though the datapath itself cannot be stalled.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   {a,b}_valid/_ready       request handshake (valid & ready)
//   {a,b}_mode               0 = rotation, 1 = vectoring
//   {a,b}_x/_y/_ang          signed operands (angle ignored when vectoring)
//   dp_valid/_mode/_x/_y/_ang issue strobe and operands to the datapath
//   dp_res0/dp_res1          datapath results, LATENCY cycles after dp_valid
//   {a,b}_rsp_valid/_ready   response FIFO head handshake
//   {a,b}_rsp_mode/_0/_1     head entry (zero while the FIFO is empty)
// -----------------------------------------------------------------------------
module cordic_req_arbiter #(
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int W          = 16
) (
  input  logic         clk,
  input  logic         rst,
  // requester A
  input  logic         a_valid,
  output logic         a_ready,
  input  logic         a_mode,
  input  logic [W-1:0] a_x,
  input  logic [W-1:0] a_y,
  input  logic [W-1:0] a_ang,
  // requester B
  input  logic         b_valid,
  output logic         b_ready,
  input  logic         b_mode,
  input  logic [W-1:0] b_x,
  input  logic [W-1:0] b_y,
  input  logic [W-1:0] b_ang,
  // datapath
  output logic         dp_valid,
  output logic         dp_mode,
  output logic [W-1:0] dp_x,
  output logic [W-1:0] dp_y,
  output logic [W-1:0] dp_ang,
  input  logic [W-1:0] dp_res0,
  input  logic [W-1:0] dp_res1,
  // responses A
  output logic         a_rsp_valid,
  input  logic         a_rsp_ready,
  output logic         a_rsp_mode,
  output logic [W-1:0] a_rsp_0,
  output logic [W-1:0] a_rsp_1,
  // responses B
  output logic         b_rsp_valid,
  input  logic         b_rsp_ready,
  output logic         b_rsp_mode,
  output logic [W-1:0] b_rsp_0,
  output logic [W-1:0] b_rsp_1
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CREDIT_INIT = CW'(FIFO_DEPTH);

  // Round-robin pointer values; index 0 is A, index 1 is B throughout.
  localparam logic [0:0] PTR_A = 1'b0;
  localparam logic [0:0] PTR_B = 1'b1;

  logic [0:0]    rr_ptr;
  logic [CW-1:0] credit [2];
  logic          elig_a, elig_b;
  logic          grant_a, grant_b;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // NOTE: combinational logic uses blocking assignments and gives every output
  // a value on every path, so no latch can be inferred.
  always_comb begin
    elig_a  = !rst && a_valid && (credit[0] != '0);
    elig_b  = !rst && b_valid && (credit[1] != '0);
    grant_a = elig_a && (!elig_b || (rr_ptr == PTR_A));
    grant_b = elig_b && (!elig_a || (rr_ptr == PTR_B));
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // ---------------------------------------------------------------------------
  // Issue register: operands held when nothing is issued.
  // ---------------------------------------------------------------------------
  logic dp_id;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_mode  <= 1'b0;
      dp_x     <= '0;
      dp_y     <= '0;
      dp_ang   <= '0;
      dp_id    <= 1'b0;
      rr_ptr   <= PTR_A;
    end else begin
      dp_valid <= grant_a | grant_b;
      if (grant_a) begin
        dp_mode <= a_mode;
        dp_x    <= a_x;
        dp_y    <= a_y;
        dp_ang  <= a_ang;
        dp_id   <= 1'b0;
        rr_ptr  <= PTR_B;
      end else if (grant_b) begin
        dp_mode <= b_mode;
        dp_x    <= b_x;
        dp_y    <= b_y;
        dp_ang  <= b_ang;
        dp_id   <= 1'b1;
        rr_ptr  <= PTR_A;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: stage LATENCY-1 lines up with the result on dp_res*.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] tag_v, tag_id, tag_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v    <= '0;
      tag_id   <= '0;
      tag_mode <= '0;
    end else begin
      tag_v[0]    <= dp_valid;
      tag_id[0]   <= dp_id;
      tag_mode[0] <= dp_mode;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_id[i]   <= tag_id[i-1];
        tag_mode[i] <= tag_mode[i-1];
      end
    end
  end

  logic ret_v, ret_id, ret_mode;
  assign ret_v    = tag_v[LATENCY-1];
  assign ret_id   = tag_id[LATENCY-1];
  assign ret_mode = tag_mode[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Response FIFOs and credits
  // ---------------------------------------------------------------------------
  logic [W-1:0]  mem_0    [2][FIFO_DEPTH];
  logic [W-1:0]  mem_1    [2][FIFO_DEPTH];
  logic          mem_mode [2][FIFO_DEPTH];
  logic [AW-1:0] wptr [2];
  logic [AW-1:0] rptr [2];
  logic [CW-1:0] count [2];
  logic [1:0]    wr, pop, issue, rsp_ready_v;

  always_comb begin
    rsp_ready_v = {b_rsp_ready, a_rsp_ready};
    issue       = {grant_b, grant_a};
    wr          = '0;
    pop         = '0;
    for (int r = 0; r < 2; r++) begin
      wr[r]  = ret_v && (ret_id == r[0]);
      pop[r] = (count[r] != '0) && rsp_ready_v[r];
    end
  end

  // NOTE: the storage arrays are not reset; occupancy is tracked by the
  // counters and the head outputs are masked while empty, so stale contents
  // are never visible.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (wr[r]) begin
        mem_0[r][wptr[r]]    <= dp_res0;
        mem_1[r][wptr[r]]    <= dp_res1;
        mem_mode[r][wptr[r]] <= ret_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        wptr[r]   <= '0;
        rptr[r]   <= '0;
        count[r]  <= '0;
        credit[r] <= CREDIT_INIT;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        // Depth is a power of two, so the pointers wrap naturally.
        if (wr[r])  wptr[r] <= wptr[r] + AW'(1);
        if (pop[r]) rptr[r] <= rptr[r] + AW'(1);
        case ({wr[r], pop[r]})
          2'b10:   count[r] <= count[r] + CW'(1);
          2'b01:   count[r] <= count[r] - CW'(1);
          default: ;
        endcase
        // Issue and pop in the same cycle cancel out.
        case ({issue[r], pop[r]})
          2'b10:   credit[r] <= credit[r] - CW'(1);
          2'b01:   credit[r] <= credit[r] + CW'(1);
          default: ;
        endcase
      end
    end
  end

  assign a_rsp_valid = (count[0] != '0);
  assign b_rsp_valid = (count[1] != '0);
  assign a_rsp_mode  = a_rsp_valid & mem_mode[0][rptr[0]];
  assign b_rsp_mode  = b_rsp_valid & mem_mode[1][rptr[1]];
  assign a_rsp_0     = a_rsp_valid ? mem_0[0][rptr[0]] : '0;
  assign a_rsp_1     = a_rsp_valid ? mem_1[0][rptr[0]] : '0;
  assign b_rsp_0     = b_rsp_valid ? mem_0[1][rptr[1]] : '0;
  assign b_rsp_1     = b_rsp_valid ? mem_1[1][rptr[1]] : '0;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for cordic_req_arbiter. A stub datapath returns x+1 and y+ang after
// LATENCY cycles. A producer process models arbitration from the credit rules
// (credit = depth - issued + popped) and queues expected issues/responses; a
// monitor process checks the datapath port and both response heads every cycle.
// -----------------------------------------------------------------------------
module tb_cordic_req_arbiter;

  localparam int LAT   = 10;
  localparam int DEPTH = 4;
  localparam int W     = 16;

  logic         clk, rst;
  logic         a_valid, a_ready, a_mode, b_valid, b_ready, b_mode;
  logic [W-1:0] a_x, a_y, a_ang, b_x, b_y, b_ang;
  logic         dp_valid, dp_mode;
  logic [W-1:0] dp_x, dp_y, dp_ang, dp_res0, dp_res1;
  logic         a_rsp_valid, a_rsp_ready, a_rsp_mode;
  logic         b_rsp_valid, b_rsp_ready, b_rsp_mode;
  logic [W-1:0] a_rsp_0, a_rsp_1, b_rsp_0, b_rsp_1;

  cordic_req_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_mode(a_mode),
    .a_x(a_x), .a_y(a_y), .a_ang(a_ang),
    .b_valid(b_valid), .b_ready(b_ready), .b_mode(b_mode),
    .b_x(b_x), .b_y(b_y), .b_ang(b_ang),
    .dp_valid(dp_valid), .dp_mode(dp_mode),
    .dp_x(dp_x), .dp_y(dp_y), .dp_ang(dp_ang),
    .dp_res0(dp_res0), .dp_res1(dp_res1),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_mode(a_rsp_mode),
    .a_rsp_0(a_rsp_0), .a_rsp_1(a_rsp_1),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_mode(b_rsp_mode),
    .b_rsp_0(b_rsp_0), .b_rsp_1(b_rsp_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub datapath: fixed LATENCY, res0 = x+1, res1 = y+ang.
  logic [W-1:0] st0 [LAT];
  logic [W-1:0] st1 [LAT];
  always @(posedge clk) begin
    st0[0] <= dp_x + W'(1);
    st1[0] <= dp_y + dp_ang;
    for (int i = 1; i < LAT; i++) begin
      st0[i] <= st0[i-1];
      st1[i] <= st1[i-1];
    end
  end
  assign dp_res0 = st0[LAT-1];
  assign dp_res1 = st1[LAT-1];

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    int           avail;
    logic         mode;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
  } rsp_t;

  typedef struct {
    int           at;
    logic         mode;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] ang;
  } op_t;

  rsp_t qa[$];
  rsp_t qb[$];
  op_t  dq[$];

  int errors = 0;
  int checks = 0;
  int issued_a = 0, issued_b = 0;   // owned by producer
  int popped_a = 0, popped_b = 0;   // owned by monitor
  logic ptr_b = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Producer: expected grants from the arbitration rules; queue expectations.
  initial begin
    int  cred_a, cred_b;
    bit  el_a, el_b, ga, gb;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("a_ready_in_reset", a_ready, 0);
        check("b_ready_in_reset", b_ready, 0);
        issued_a = 0;
        issued_b = 0;
        ptr_b    = 1'b0;
        qa.delete();
        qb.delete();
        dq.delete();
      end else begin
        cred_a = DEPTH - (issued_a - popped_a);
        cred_b = DEPTH - (issued_b - popped_b);
        el_a = a_valid && (cred_a > 0);
        el_b = b_valid && (cred_b > 0);
        ga = el_a && (!el_b || !ptr_b);
        gb = el_b && (!el_a || ptr_b);
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        if (ga) begin
          qa.push_back('{cyc + LAT + 2, a_mode, a_x + W'(1), a_y + a_ang});
          dq.push_back('{cyc + 1, a_mode, a_x, a_y, a_ang});
          issued_a++;
          ptr_b = 1'b1;
        end else if (gb) begin
          qb.push_back('{cyc + LAT + 2, b_mode, b_x + W'(1), b_y + b_ang});
          dq.push_back('{cyc + 1, b_mode, b_x, b_y, b_ang});
          issued_b++;
          ptr_b = 1'b0;
        end
      end
    end
  end

  // Monitor: checks the datapath port and both response heads each cycle.
  initial begin
    op_t  hold;
    rsp_t e;
    bit   pend_a, pend_b, post_rst, exp_v;
    hold = '{0, 1'b0, '0, '0, '0};
    pend_a = 0; pend_b = 0; post_rst = 0;
    forever begin
      @(posedge clk);
      #2;
      // A pop during the previous cycle frees its credit from this cycle on.
      popped_a += int'(pend_a);
      popped_b += int'(pend_b);
      pend_a = 0;
      pend_b = 0;

      if (dq.size() > 0 && dq[0].at == cyc) begin
        hold = dq.pop_front();
        check("dp_valid_issue", dp_valid, 1);
      end else begin
        check("dp_valid_idle", dp_valid, 0);
      end
      check("dp_mode", dp_mode, hold.mode);
      check("dp_x", dp_x, hold.x);
      check("dp_y", dp_y, hold.y);
      check("dp_ang", dp_ang, hold.ang);

      exp_v = (qa.size() > 0) && (qa[0].avail <= cyc);
      check("a_rsp_valid", a_rsp_valid, exp_v);
      if (exp_v) begin
        e = qa[0];
        check("a_rsp_mode", a_rsp_mode, e.mode);
        check("a_rsp_0", a_rsp_0, e.r0);
        check("a_rsp_1", a_rsp_1, e.r1);
        if (a_rsp_ready && !rst) begin
          void'(qa.pop_front());
          pend_a = 1;
        end
      end

      exp_v = (qb.size() > 0) && (qb[0].avail <= cyc);
      check("b_rsp_valid", b_rsp_valid, exp_v);
      if (exp_v) begin
        e = qb[0];
        check("b_rsp_mode", b_rsp_mode, e.mode);
        check("b_rsp_0", b_rsp_0, e.r0);
        check("b_rsp_1", b_rsp_1, e.r1);
        if (b_rsp_ready && !rst) begin
          void'(qb.pop_front());
          pend_b = 1;
        end
      end

      if (post_rst) begin
        check("a_rsp_data_after_reset", {a_rsp_mode, a_rsp_0, a_rsp_1}, 0);
        check("b_rsp_data_after_reset", {b_rsp_mode, b_rsp_0, b_rsp_1}, 0);
      end
      post_rst = rst;
      if (rst) begin
        popped_a = 0;
        popped_b = 0;
        pend_a   = 0;
        pend_b   = 0;
        hold     = '{0, 1'b0, '0, '0, '0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    a_mode = 1'($urandom); a_x = W'($urandom); a_y = W'($urandom); a_ang = W'($urandom);
    b_mode = 1'($urandom); b_x = W'($urandom); b_y = W'($urandom); b_ang = W'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic run(input int n, input bit va, input bit vb, input bit ra, input bit rb);
    a_valid = va; b_valid = vb; a_rsp_ready = ra; b_rsp_ready = rb;
    repeat (n) begin
      rand_ops();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
    a_mode = 0; a_x = '0; a_y = '0; a_ang = '0;
    b_mode = 0; b_x = '0; b_y = '0; b_ang = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single rotation request from A: response exactly LATENCY+2 cycles later.
    a_rsp_ready = 1; b_rsp_ready = 1;
    a_valid = 1; a_mode = 0; a_x = 16'd1000; a_y = 16'd0; a_ang = 16'd3000;
    tick();
    a_valid = 0;
    repeat (10) tick();
    check("single_not_early", a_rsp_valid, 0);
    tick();
    check("single_rsp_valid", a_rsp_valid, 1);
    check("single_rsp_0", a_rsp_0, 1001);
    check("single_rsp_1", a_rsp_1, 3000);
    check("single_b_idle", b_rsp_valid, 0);
    repeat (4) tick();

    // Contention: alternate A,B starting with A.
    do_reset(1);
    run(24, 1, 1, 1, 1);
    run(16, 0, 0, 1, 1);

    // Backpressure on A, then release.
    do_reset(1);
    run(16, 1, 1, 0, 1);
    run(20, 1, 1, 1, 1);
    run(16, 0, 0, 1, 1);

    // Same-cycle issue and pop with one credit left.
    do_reset(1);
    run(3, 1, 0, 0, 0);
    run(14, 0, 0, 0, 0);
    run(1, 1, 0, 1, 0);
    run(3, 1, 0, 0, 0);
    run(20, 0, 0, 1, 1);

    // Only B requesting, no pops: four issues then stalled.
    do_reset(1);
    run(20, 0, 1, 0, 0);
    run(16, 0, 0, 1, 1);

    // Randomised traffic.
    do_reset(1);
    repeat (400) begin
      a_valid = ($urandom_range(0, 9) < 7);
      b_valid = ($urandom_range(0, 9) < 7);
      a_rsp_ready = ($urandom_range(0, 9) < 6);
      b_rsp_ready = ($urandom_range(0, 9) < 6);
      rand_ops();
      tick();
    end
    run(20, 0, 0, 1, 1);

    // Reset while operations are in flight.
    run(3, 1, 1, 1, 1);
    run(3, 0, 0, 1, 1);
    do_reset(1);
    run(LAT + 4, 0, 0, 1, 1);
    run(1, 1, 0, 1, 1);
    run(LAT + 6, 0, 0, 1, 1);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
